// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
// Holds the op encodings, FSM state encoding and default datapath width.
// Imported by muldiv_sequencer and muldiv_step.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_FIXUP = 2'b10
  } state_t;

  function automatic logic is_signed_op(input op_t o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the shared multiply/divide datapath.
// Ports: is_div selects restoring-divide vs shift-add; acc/q are the working
// pair {HI-side accumulator, LO-side operand}; m is multiplicand or divisor.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] q,
  input  logic [XLEN-1:0] m,
  output logic [XLEN-1:0] acc_nxt,
  output logic [XLEN-1:0] q_nxt
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shl;
  logic [XLEN:0] diff;

  always_comb begin
    sum  = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    shl  = {acc, q[XLEN-1]};
    diff = shl - {1'b0, m};
    if (is_div) begin
      // The partial remainder always stays below the divisor, so the top
      // bit of diff is a clean borrow flag: clear means the subtract fits.
      if (!diff[XLEN]) begin
        acc_nxt = diff[XLEN-1:0];
        q_nxt   = {q[XLEN-2:0], 1'b1};
      end else begin
        acc_nxt = shl[XLEN-1:0];
        q_nxt   = {q[XLEN-2:0], 1'b0};
      end
    end else begin
      // Right-shifting the {carry,acc,q} product register by one.
      acc_nxt = sum[XLEN:1];
      q_nxt   = {sum[0], q[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Controller for the shared iterative multiply/divide unit and HI/LO pair.
// Ports: start/op/rs_val/rt_val launch an op; mf_req/mt_hi/mt_lo/mt_data access
// HI/LO; flush squashes; hi/lo/busy/done/stall report status to the pipeline.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            mf_req,
  input  logic            mt_hi,
  input  logic            mt_lo,
  input  logic [XLEN-1:0] mt_data,
  input  logic            flush,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done,
  output logic            stall
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   acc, q, m;
  logic [XLEN-1:0]   acc_nxt, q_nxt;
  logic              is_div, neg_res, neg_rem, div_zero;

  logic              sgn;
  logic [XLEN-1:0]   rs_mag, rt_mag;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div  (is_div),
    .acc     (acc),
    .q       (q),
    .m       (m),
    .acc_nxt (acc_nxt),
    .q_nxt   (q_nxt)
  );

  always_comb begin
    sgn    = is_signed_op(op_t'(op));
    rs_mag = (sgn && rs_val[XLEN-1]) ? -rs_val : rs_val;
    rt_mag = (sgn && rt_val[XLEN-1]) ? -rt_val : rt_val;
  end

  // Sign fix-up on the magnitude result. Divide-by-zero leaves the
  // remainder equal to the dividend magnitude, so restoring its sign gives
  // back rs_val; only the quotient needs forcing to all ones.
  always_comb begin
    prod_fix = neg_res ? -{acc, q} : {acc, q};
    quo_fix  = div_zero ? '1 : (neg_res ? -q : q);
    rem_fix  = neg_rem ? -acc : acc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && !flush) state_nxt = S_RUN;
      S_RUN: begin
        if (flush)                          state_nxt = S_IDLE;
        else if (cnt == CNT_W'(XLEN - 1))   state_nxt = S_FIXUP;
      end
      S_FIXUP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      q        <= '0;
      m        <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (!flush) begin
          if (mt_hi) hi <= mt_data;
          if (mt_lo) lo <= mt_data;
          if (start) begin
            cnt      <= '0;
            acc      <= '0;
            is_div   <= op[1];
            // Multiply walks the multiplier through q; divide shifts the
            // dividend out of q while the quotient shifts in behind it.
            q        <= op[1] ? rs_mag : rt_mag;
            m        <= op[1] ? rt_mag : rs_mag;
            neg_res  <= sgn && (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
            neg_rem  <= sgn && rs_val[XLEN-1];
            div_zero <= op[1] && (rt_val == '0);
          end
        end
        S_RUN: if (!flush) begin
          acc <= acc_nxt;
          q   <= q_nxt;
          cnt <= cnt + 1'b1;
        end
        S_FIXUP: if (!flush) begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*XLEN-1:XLEN];
            lo <= prod_fix[XLEN-1:0];
          end
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy  = (state != S_IDLE);
    stall = (start | mf_req | mt_hi | mt_lo) & busy;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        mf_req, mt_hi, mt_lo;
  logic [31:0] mt_data;
  logic        flush;
  logic [31:0] hi, lo;
  logic        busy, done, stall;

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .mf_req(mf_req),
    .mt_hi(mt_hi), .mt_lo(mt_lo), .mt_data(mt_data), .flush(flush),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t        tbl [10];
  logic [63:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_hi, cur_lo;
  int          lat, nbusy, nstall, ndone;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge: presents an op for the next posedge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input bit push);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    if (push) exp_q.push_back({eh, el});
  endtask

  // Entered at the first negedge after the accepting edge; returns at the
  // negedge where done is seen, with latency counted in edges from acceptance.
  task automatic wait_done(output int l, output int nb, output int ns);
    logic [63:0] e;
    l = 1; nb = 0; ns = 0;
    while (!done && l < 60) begin
      if (busy)  nb++;
      if (stall) ns++;
      @(negedge clk);
      l++;
    end
    if (!done) begin
      chk("done_timeout", 64'd0, 64'd1);
    end else if (exp_q.size() == 0) begin
      chk("unexpected_done", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk("result_hi", {32'd0, hi}, {32'd0, e[63:32]});
      chk("result_lo", {32'd0, lo}, {32'd0, e[31:0]});
      cur_hi = e[63:32];
      cur_lo = e[31:0];
    end
  endtask

  initial begin
    tbl[0] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
    tbl[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tbl[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3] = '{2'b11, 32'd26,        32'd0,         32'd26,        32'hFFFF_FFFF};
    tbl[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    tbl[5] = '{2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0000_0000, 32'h0000_001E};
    tbl[6] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
    tbl[7] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    tbl[8] = '{2'b10, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF};
    tbl[9] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};

    rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    mf_req = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0; mt_data = '0; flush = 1'b0;
    cur_hi = '0; cur_lo = '0;
    repeat (2) @(negedge clk);
    chk("reset_hi",    {32'd0, hi}, 64'd0);
    chk("reset_lo",    {32'd0, lo}, 64'd0);
    chk("reset_busy",  {63'd0, busy}, 64'd0);
    chk("reset_done",  {63'd0, done}, 64'd0);
    chk("reset_stall", {63'd0, stall}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table of ops: result, latency, busy length, single-cycle done.
    for (int i = 0; i < 10; i++) begin
      issue(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].hi, tbl[i].lo, 1'b1);
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, nbusy, nstall);
      chk($sformatf("latency_%0d", i), 64'(lat), 64'd34);
      chk($sformatf("busy_cycles_%0d", i), 64'(nbusy), 64'd33);
      chk($sformatf("done_busy_%0d", i), {63'd0, busy}, 64'd0);
      @(negedge clk);
      chk($sformatf("done_pulse_%0d", i), {63'd0, done}, 64'd0);
    end

    // mf_req held through a MULT: stalls every busy cycle, free in done cycle.
    issue(2'b00, 32'd12, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFE8, 1'b1);
    @(negedge clk);
    start  = 1'b0;
    mf_req = 1'b1;
    wait_done(lat, nbusy, nstall);
    chk("mf_stall_cycles", 64'(nstall), 64'd33);
    chk("mf_stall_done",   {63'd0, stall}, 64'd0);
    mf_req = 1'b0;
    @(negedge clk);

    // Second start held while busy: stalled, then accepted after done.
    issue(2'b00, 32'd1000, 32'd1000, 32'd0, 32'h000F_4240, 1'b1);
    @(negedge clk);
    issue(2'b11, 32'hFFFF_FFFF, 32'd16, 32'd15, 32'h0FFF_FFFF, 1'b0);
    wait_done(lat, nbusy, nstall);
    chk("start_stall_cycles", 64'(nstall), 64'd33);
    chk("start_stall_done",   {63'd0, stall}, 64'd0);
    exp_q.push_back({32'd15, 32'h0FFF_FFFF});
    @(negedge clk);
    start = 1'b0;
    chk("restart_busy", {63'd0, busy}, 64'd1);
    wait_done(lat, nbusy, nstall);
    chk("restart_latency", 64'(lat), 64'd34);
    @(negedge clk);

    // mt_lo and start on the same IDLE edge: both taken, op overwrites.
    mt_lo = 1'b1; mt_data = 32'h0000_AAAA;
    issue(2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b1);
    @(negedge clk);
    start = 1'b0; mt_lo = 1'b0;
    chk("mt_start_lo",   {32'd0, lo}, 64'h0000_AAAA);
    chk("mt_start_busy", {63'd0, busy}, 64'd1);
    wait_done(lat, nbusy, nstall);
    @(negedge clk);

    // Flush on the 10th RUN edge of DIVU 26/2; mt_lo while busy is ignored.
    issue(2'b11, 32'd26, 32'd2, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    mt_lo = 1'b1; mt_data = 32'h5555_5555;
    repeat (9) @(negedge clk);
    chk("mt_busy_stall", {63'd0, stall}, 64'd1);
    mt_lo = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_hi",   {32'd0, hi}, {32'd0, cur_hi});
    chk("flush_lo",   {32'd0, lo}, {32'd0, cur_lo});
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("flush_no_done", 64'(ndone), 64'd0);

    // flush with start and mt_hi in IDLE: everything dropped.
    flush = 1'b1; mt_hi = 1'b1; mt_data = 32'h7777_7777;
    issue(2'b01, 32'd9, 32'd9, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    flush = 1'b0; mt_hi = 1'b0; start = 1'b0;
    chk("flush_idle_busy", {63'd0, busy}, 64'd0);
    chk("flush_idle_hi",   {32'd0, hi}, {32'd0, cur_hi});

    // MTHI in IDLE, then reset mid-MULT.
    mt_hi = 1'b1; mt_data = 32'h0000_1234;
    @(negedge clk);
    mt_hi = 1'b0;
    chk("mthi_write", {32'd0, hi}, 64'h0000_1234);
    issue(2'b00, 32'd5, 32'd5, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_hi",   {32'd0, hi}, 64'd0);
    chk("rst_mid_lo",   {32'd0, lo}, 64'd0);
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_done", {63'd0, done}, 64'd0);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("rst_no_done", 64'(ndone), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
